// File: rtl/i2s_clk_gen.sv
// I2S clock generator: MCLK, BCLK and LRCK from clk_in, with serializer strobes.
// Divide ratios are held in shadow registers and only reloaded on frame
// boundaries, so the codec never sees a shortened clock phase.
module i2s_clk_gen #(
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned SLOT_BITS     = 32,
    parameter int unsigned RST_MCLK_HALF = 4,
    parameter int unsigned RST_BCLK_HALF = 8
) (
    input  logic             clk_in,
    input  logic             ar,
    input  logic             enable,
    input  logic [DIV_W-1:0] mclk_half,
    input  logic [DIV_W-1:0] bclk_half,
    output logic             mclk,
    output logic             bclk,
    output logic             lrck,
    output logic             bclk_fall,
    output logic             frame_start,
    output logic             running
);

    localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;

    logic [DIV_W-1:0]   mcnt_q, mcnt_d;
    logic [DIV_W-1:0]   mshadow_q, mshadow_d;
    logic               mclk_q, mclk_d;
    logic [DIV_W-1:0]   mlimit;

    logic [DIV_W-1:0]   bcnt_q;
    logic [DIV_W-1:0]   bshadow_q;
    logic [BIT_W-1:0]   bit_q;
    logic               bclk_q;
    logic               lrck_q;
    logic               bclk_fall_q;
    logic               frame_start_q;
    logic               running_q;
    logic [DIV_W-1:0]   blimit;

    logic               bclk_tick;
    logic               bclk_fall_ev;
    logic               slot_wrap;
    logic               frame_end;
    logic               frame_start_ev;
    logic               bshadow_load;

    // Terminal counts; a zero half-period behaves as one.
    always_comb begin
        mlimit = (mshadow_q == '0) ? '0 : mshadow_q - DIV_W'(1);
        blimit = (bshadow_q == '0) ? '0 : bshadow_q - DIV_W'(1);
    end

    // BCLK/LRCK event decode shared by the FSM and the MCLK shadow load.
    always_comb begin
        bclk_tick      = (state_q == ST_RUN) && (bcnt_q >= blimit);
        bclk_fall_ev   = bclk_tick && bclk_q;
        slot_wrap      = bclk_fall_ev && (bit_q == LAST_BIT);
        frame_end      = slot_wrap && lrck_q;
        frame_start_ev = ((state_q == ST_IDLE) && enable) || (frame_end && enable);
        bshadow_load   = (state_q == ST_IDLE) || frame_start_ev;
    end

    // MCLK divider next state; free-running whenever out of reset.
    always_comb begin
        mcnt_d    = mcnt_q + DIV_W'(1);
        mclk_d    = mclk_q;
        mshadow_d = mshadow_q;
        if (mcnt_q >= mlimit) begin
            mcnt_d = '0;
            mclk_d = ~mclk_q;
        end
        if (!running_q || frame_start_ev) begin
            mshadow_d = mclk_half;
        end
    end

    // MCLK divider registers.
    always_ff @(posedge clk_in or negedge ar) begin
        if (!ar) begin
            mcnt_q    <= '0;
            mclk_q    <= 1'b0;
            mshadow_q <= DIV_W'(RST_MCLK_HALF);
        end else begin
            mcnt_q    <= mcnt_d;
            mclk_q    <= mclk_d;
            mshadow_q <= mshadow_d;
        end
    end

    // BCLK/LRCK state machine with registered clocks and strobes.
    always_ff @(posedge clk_in or negedge ar) begin
        if (!ar) begin
            state_q       <= ST_IDLE;
            bcnt_q        <= '0;
            bshadow_q     <= DIV_W'(RST_BCLK_HALF);
            bit_q         <= '0;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            bclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            bclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
            if (bshadow_load) begin
                bshadow_q <= bclk_half;
            end
            case (state_q)
                ST_IDLE: begin
                    bcnt_q    <= '0;
                    bit_q     <= '0;
                    bclk_q    <= 1'b0;
                    lrck_q    <= 1'b0;
                    running_q <= 1'b0;
                    if (enable) begin
                        state_q       <= ST_RUN;
                        running_q     <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bclk_tick) begin
                        bcnt_q <= '0;
                        bclk_q <= ~bclk_q;
                    end else begin
                        bcnt_q <= bcnt_q + DIV_W'(1);
                    end
                    if (bclk_fall_ev) begin
                        bclk_fall_q <= 1'b1;
                        if (slot_wrap) begin
                            bit_q  <= '0;
                            lrck_q <= ~lrck_q;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                    // Frame boundary: either start the next frame or stop cleanly.
                    if (frame_end) begin
                        if (enable) begin
                            frame_start_q <= 1'b1;
                        end else begin
                            state_q   <= ST_IDLE;
                            bclk_q    <= 1'b0;
                            lrck_q    <= 1'b0;
                            running_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mclk        = mclk_q;
    assign bclk        = bclk_q;
    assign lrck        = lrck_q;
    assign bclk_fall   = bclk_fall_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Directed bench for i2s_clk_gen with SLOT_BITS=4 and legacy reset ratios.
module tb_i2s_clk_gen;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned SLOT  = 4;

    logic             clk_in = 1'b0;
    logic             ar;
    logic             enable;
    logic [DIV_W-1:0] mclk_half;
    logic [DIV_W-1:0] bclk_half;
    logic             mclk;
    logic             bclk;
    logic             lrck;
    logic             bclk_fall;
    logic             frame_start;
    logic             running;

    int n_checks = 0;
    int n_errors = 0;

    i2s_clk_gen #(
        .DIV_W        (DIV_W),
        .SLOT_BITS    (SLOT),
        .RST_MCLK_HALF(4),
        .RST_BCLK_HALF(8)
    ) dut (
        .clk_in     (clk_in),
        .ar         (ar),
        .enable     (enable),
        .mclk_half  (mclk_half),
        .bclk_half  (bclk_half),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrck       (lrck),
        .bclk_fall  (bclk_fall),
        .frame_start(frame_start),
        .running    (running)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clk_in edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mclk"},  32'(mclk),        0);
        check({tag, "_bclk"},  32'(bclk),        0);
        check({tag, "_lrck"},  32'(lrck),        0);
        check({tag, "_fall"},  32'(bclk_fall),   0);
        check({tag, "_fs"},    32'(frame_start), 0);
        check({tag, "_run"},   32'(running),     0);
    endtask

    // Hold reset for two edges, then release just after an edge.
    task automatic apply_reset(input logic [DIV_W-1:0] mh, input logic [DIV_W-1:0] bh);
        ar        = 1'b0;
        enable    = 1'b0;
        mclk_half = mh;
        bclk_half = bh;
        tick();
        tick();
        ar = 1'b1;
    endtask

    // Idle MCLK with half-period 4: toggles on edges 4, 8, 12, 16 after release.
    task automatic check_mclk_legacy(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check({tag, "_mclk"}, 32'(mclk), 32'((i / 4) % 2));
        end
        check({tag, "_bclk"}, 32'(bclk),        0);
        check({tag, "_lrck"}, 32'(lrck),        0);
        check({tag, "_run"},  32'(running),     0);
        check({tag, "_fs"},   32'(frame_start), 0);
        check({tag, "_fall"}, 32'(bclk_fall),   0);
    endtask

    initial begin
        int   last_tog;
        int   n_tog;
        logic prev_mclk;
        int   j;

        ar        = 1'b0;
        enable    = 1'b0;
        mclk_half = 8'd4;
        bclk_half = 8'd8;
        #1;
        check_all_zero("rst_async");

        // Idle after reset: legacy divide-by-8 MCLK, everything else quiet.
        apply_reset(8'd4, 8'd8);
        check_all_zero("rst_held");
        check_mclk_legacy("idle");

        // Run with bclk_half=2, change both ratios mid-frame.
        apply_reset(8'd4, 8'd2);
        enable = 1'b1;
        tick();
        check("e0_fs",   32'(frame_start), 1);
        check("e0_run",  32'(running),     1);
        check("e0_bclk", 32'(bclk),        0);
        check("e0_lrck", 32'(lrck),        0);
        prev_mclk = mclk;
        last_tog  = -1;
        n_tog     = 0;
        for (int k = 1; k <= 75; k++) begin
            tick();
            if (k <= 32) begin
                check("run_bclk", 32'(bclk),        32'((k / 2) % 2));
                check("run_fall", 32'(bclk_fall),   32'(k % 4 == 0));
                check("run_lrck", 32'(lrck),        32'((k / 16) % 2));
                check("run_fs",   32'(frame_start), 32'(k == 32));
            end else begin
                j = k - 32;
                check("chg_bclk", 32'(bclk),        32'((j / 5) % 2));
                check("chg_fall", 32'(bclk_fall),   32'(j % 10 == 0));
                check("chg_lrck", 32'(lrck),        32'(j >= 40));
                check("chg_fs",   32'(frame_start), 0);
            end
            check("run_running", 32'(running), 1);
            if (mclk != prev_mclk) begin
                n_tog++;
                if (last_tog >= 0) begin
                    if (k <= 32)
                        check("mclk_int_pre", 32'(k - last_tog), 4);
                    else if (last_tog >= 32)
                        check("mclk_int_post", 32'(k - last_tog), 6);
                end
                last_tog = k;
            end
            prev_mclk = mclk;
            if (k == 5) begin
                bclk_half = 8'd5;
                mclk_half = 8'd6;
            end
        end
        check("mclk_toggles", 32'(n_tog), 15);

        // Asynchronous reset in the middle of a slot.
        #3;
        ar = 1'b0;
        #1;
        check_all_zero("rst_mid");
        mclk_half = 8'd4;
        bclk_half = 8'd2;
        enable    = 1'b0;
        tick();
        tick();
        ar = 1'b1;
        check_mclk_legacy("post_rst");

        // Enable dropped mid-frame: the frame completes, then generation stops.
        apply_reset(8'd4, 8'd2);
        enable = 1'b1;
        tick();
        check("dis_e0_fs", 32'(frame_start), 1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k < 32) begin
                check("dis_bclk", 32'(bclk),        32'((k / 2) % 2));
                check("dis_lrck", 32'(lrck),        32'((k / 16) % 2));
                check("dis_run",  32'(running),     1);
                check("dis_fs",   32'(frame_start), 0);
            end else begin
                check("dis_end_bclk", 32'(bclk),        0);
                check("dis_end_lrck", 32'(lrck),        0);
                check("dis_end_run",  32'(running),     0);
                check("dis_end_fs",   32'(frame_start), 0);
            end
            if (k == 8) enable = 1'b0;
        end
        enable = 1'b1;
        tick();
        check("reen_fs",  32'(frame_start), 1);
        check("reen_run", 32'(running),     1);

        // Zero half-periods behave as one.
        apply_reset(8'd0, 8'd0);
        tick();
        tick();
        tick();
        prev_mclk = mclk;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("zero_mclk_toggle", 32'(mclk != prev_mclk), 1);
            prev_mclk = mclk;
        end
        enable = 1'b1;
        tick();
        check("zero_e0_fs", 32'(frame_start), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("zero_bclk", 32'(bclk),      32'(k % 2));
            check("zero_fall", 32'(bclk_fall), 32'(k % 2 == 0));
            check("zero_lrck", 32'(lrck),      32'(k >= 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
